// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer: one-hot stage enables, run/step control, bounded MWAIT, fault halt.
// Define STAGE_PERF_CNT_EN to build the instr_count / stall_count performance counters.
module stage_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic        sysclk,
    input  logic        cpu_reset,
    input  logic        run,
    input  logic        step,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        busy,
    output logic        fault,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F,
        S_D,
        S_E,
        S_M,
        S_MWAIT,
        S_W,
        S_HALT
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_WAIT_MAX - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:  if (run || step) state_d = S_F;
            S_F:     state_d = S_D;
            S_D:     state_d = S_E;
            S_E:     state_d = S_M;
            S_M: begin
                if (mem_req && !mem_ack) begin
                    state_d = S_MWAIT;
                    wait_d  = '0;
                end else begin
                    state_d = S_W;
                end
            end
            S_MWAIT: begin
                if (mem_ack) begin
                    state_d = S_W;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_W:     state_d = run ? S_F : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            f_en    <= 1'b0;
            d_en    <= 1'b0;
            e_en    <= 1'b0;
            m_en    <= 1'b0;
            w_en    <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            f_en    <= (state_d == S_F);
            d_en    <= (state_d == S_D);
            e_en    <= (state_d == S_E);
            m_en    <= (state_d == S_M);
            w_en    <= (state_d == S_W);
            busy    <= (state_d != S_IDLE) && (state_d != S_HALT);
            fault   <= (state_d == S_HALT);
        end
    end

`ifdef STAGE_PERF_CNT_EN
    logic [31:0] instr_q;
    logic [31:0] stall_q;

    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == S_W)     instr_q <= instr_q + 32'd1;
            if (state_q == S_MWAIT) stall_q <= stall_q + 32'd1;
        end
    end

    assign instr_count = instr_q;
    assign stall_count = stall_q;
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle instruction sequencer for the five-stage CPU (fetch, decode, execute, datamem, writeback). It replaces free-running derived stage clocks with one-hot, sysclk-synchronous stage enables. It also adds run/single-step control, a bounded wait state for slow memory-stage targets (UART, MMIO), and a fault halt. Stage modules clock on sysclk and qualify their registers with the matching enable.

## Interface
Parameters:
- MEM_WAIT_MAX, default 255: maximum cycles spent in MWAIT before a timeout fault. Legal range is 1..65535.

Ports:
- sysclk, input, 1: single system clock. All logic is rising-edge.
- cpu_reset, input, 1: asynchronous, active-high reset.
- run, input, 1: level. While high, instructions issue back-to-back.
- step, input, 1: single-cycle pulse. Sampled only in IDLE; executes exactly one instruction.
- mem_req, input, 1: sampled during M. High means the memory-stage access needs more cycles.
- mem_ack, input, 1: memory-stage access complete. Sampled in M and MWAIT.
- f_en / d_en / e_en / m_en / w_en, output, 1 each: stage enables. At most one is high per cycle.
- busy, output, 1: high in every state except IDLE and HALT.
- fault, output, 1: high in HALT.
- instr_count, output, 32: retired instructions, counted in W cycles.
- stall_count, output, 32: number of cycles spent in MWAIT.

## Operation
States: IDLE, F, D, E, M, MWAIT, W, HALT. One state register. All outputs are decoded from registered state (Moore).

Transitions:
- IDLE → F if run=1 or step=1. Otherwise stay in IDLE.
- F → D → E → M: one cycle each, unconditional.
- M:
  - mem_req=0 → W.
  - mem_req=1 and mem_ack=1 → W (zero-wait completion).
  - mem_req=1 and mem_ack=0 → MWAIT. The wait counter loads 0.
- MWAIT:
  - mem_ack=1 → W.
  - mem_ack=0 → wait counter +1.
  - If the counter equals MEM_WAIT_MAX-1 and mem_ack=0 → HALT.
  - mem_req is ignored in MWAIT.
- W: instr_count +1 (wraps 2^32-1 → 0). Then run=1 → F; run=0 → IDLE.
- HALT: terminal. Only cpu_reset exits it.

Other rules:
- run falling mid-instruction does not abort; the current instruction completes through W.
- step arriving outside IDLE is ignored (not queued).
- If step=1 and run=1 arrive together in IDLE, the result is identical to run=1.
- Enables and states:
  - f_en only in F, d_en only in D, e_en only in E, m_en only in M, w_en only in W.
  - All enables are 0 in IDLE, MWAIT and HALT.
- Wait counter width: 16 bits.

## Timing
- Reset values: state=IDLE; all enables=0; busy=0; fault=0; instr_count=0; stall_count=0; wait counter=0.
- Async reset mid-instruction: state returns to IDLE immediately; the partial instruction is discarded; counters clear.
- Latency from run rising to f_en: 1 cycle (the IDLE cycle that samples run, then F).
- Zero-wait instruction: 5 cycles (F, D, E, M, W). Steady-state throughput is 1 instruction per 5 cycles.
- Wait-state instruction: 5 + N cycles, where N = number of MWAIT cycles (1..MEM_WAIT_MAX).
- stall_count increments once per MWAIT cycle, including the final cycle in which mem_ack is seen.
- Timeout: fault rises on the cycle after the MEM_WAIT_MAX-th MWAIT cycle without mem_ack. w_en never asserts for that instruction.
- mem_ack pulses seen outside M/MWAIT are ignored.

## Configuration
- STAGE_PERF_CNT_EN defined: instr_count and stall_count are implemented as described.
- STAGE_PERF_CNT_EN undefined: no counter registers are built; instr_count and stall_count are tied to 32'd0. Sequencing, MWAIT and timeout behaviour are unchanged.

## Test plan
- Reset, then run=1 held, mem_req=0: f_en first high on cycle 2 after reset release. Enable pattern repeats F,D,E,M,W every 5 cycles. instr_count=4 after 20 cycles of issue.
- run=0, step pulse in IDLE: exactly one F..W sequence, then return to IDLE with busy=0 and instr_count +1. A second step pulse during E is ignored.
- In M, mem_req=1 and mem_ack=0; mem_ack arrives on the 3rd MWAIT cycle: w_en on the next cycle, stall_count=3, instruction latency 8 cycles.
- MEM_WAIT_MAX=4, mem_req=1, mem_ack never: 4 MWAIT cycles, then fault=1 and busy=0. All enables stay 0 until cpu_reset. w_en is never seen.
- cpu_reset asserted during E: all outputs return to reset values asynchronously, without waiting for a clock edge. After release with run=1, sequencing restarts at F.
- Build without STAGE_PERF_CNT_EN and run 10 instructions: instr_count=0 and stall_count=0, with enable sequence identical to the first scenario.
